// File: rtl/alu_pkg.sv
// Shared types and constants for the nibble-serial 8-bit add/subtract path.
package alu_pkg;

  localparam int NIBBLE_W = 4;
  localparam int WORD_W   = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LO_REQ = 3'd1,
    S_LO_GAP = 3'd2,
    S_HI_REQ = 3'd3,
    S_HI_GAP = 3'd4,
    S_FIN    = 3'd5
  } state_t;

endpackage

// File: rtl/nibble_add_sequencer.sv
// Drives a 4-bit adder slice twice (low nibble, then high nibble) to form an
// 8-bit add or subtract, chaining the carry and reporting result and flags.
module nibble_add_sequencer
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_sub,
  input  logic [WORD_W-1:0]   x,
  input  logic [WORD_W-1:0]   y,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [WORD_W-1:0]   result,
  output logic                carry,
  output logic                overflow,
  output logic                zero,
  output logic                add_en,
  output logic [NIBBLE_W-1:0] add_a,
  output logic [NIBBLE_W-1:0] add_b,
  output logic                add_cin,
  input  logic [NIBBLE_W-1:0] add_sum,
  input  logic                add_cout,
  input  logic                add_ready,
  output state_t              dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Slice handshake: add_en rises with add_a/add_b/add_cin and all three stay
  // frozen until add_ready is seen while add_en=1 (or the wait times out);
  // add_en then drops for at least one cycle and request lines return to 0.

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NIBBLE_W-1:0] x_hi_q, x_hi_d;
  logic [NIBBLE_W-1:0] y_hi_q, y_hi_d;
  logic [NIBBLE_W-1:0] lo_q, lo_d;
  logic                cin_hi_q, cin_hi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [WORD_W-1:0]   result_q, result_d;
  logic                carry_q, carry_d;
  logic                overflow_q, overflow_d;
  logic                zero_q, zero_d;
  logic                add_en_q, add_en_d;
  logic [NIBBLE_W-1:0] add_a_q, add_a_d;
  logic [NIBBLE_W-1:0] add_b_q, add_b_d;
  logic                add_cin_q, add_cin_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_hi_d     = x_hi_q;
    y_hi_d     = y_hi_q;
    lo_d       = lo_q;
    cin_hi_d   = cin_hi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    add_en_d   = add_en_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_cin_d  = add_cin_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // y is stored pre-inverted for subtract so both nibbles reuse it as-is.
          x_hi_d    = x[WORD_W-1:NIBBLE_W];
          y_hi_d    = (op_sub == OP_SUB) ? ~y[WORD_W-1:NIBBLE_W] : y[WORD_W-1:NIBBLE_W];
          cnt_d     = '0;
          busy_d    = 1'b1;
          add_en_d  = 1'b1;
          add_a_d   = x[NIBBLE_W-1:0];
          add_b_d   = (op_sub == OP_SUB) ? ~y[NIBBLE_W-1:0] : y[NIBBLE_W-1:0];
          add_cin_d = op_sub;
          state_d   = S_LO_REQ;
        end
      end
      S_LO_REQ, S_HI_REQ: begin
        if (add_ready) begin
          add_en_d  = 1'b0;
          add_a_d   = '0;
          add_b_d   = '0;
          add_cin_d = 1'b0;
          if (state_q == S_LO_REQ) begin
            lo_d     = add_sum;
            cin_hi_d = add_cout;
            state_d  = S_LO_GAP;
          end else begin
            result_d   = {add_sum, lo_q};
            carry_d    = add_cout;
            overflow_d = (x_hi_q[NIBBLE_W-1] == y_hi_q[NIBBLE_W-1]) &&
                         (add_sum[NIBBLE_W-1] != x_hi_q[NIBBLE_W-1]);
            zero_d     = ({add_sum, lo_q} == '0);
            state_d    = S_HI_GAP;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          add_en_d  = 1'b0;
          add_a_d   = '0;
          add_b_d   = '0;
          add_cin_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LO_GAP: begin
        cnt_d     = '0;
        add_en_d  = 1'b1;
        add_a_d   = x_hi_q;
        add_b_d   = y_hi_q;
        add_cin_d = cin_hi_q;
        state_d   = S_HI_REQ;
      end
      S_HI_GAP: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      x_hi_q     <= '0;
      y_hi_q     <= '0;
      lo_q       <= '0;
      cin_hi_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      add_en_q   <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_cin_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_hi_q     <= x_hi_d;
      y_hi_q     <= y_hi_d;
      lo_q       <= lo_d;
      cin_hi_q   <= cin_hi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      add_en_q   <= add_en_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_cin_q  <= add_cin_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign add_en    = add_en_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Bench for nibble_add_sequencer: a latency-programmable adder slice model,
// directed corner cases, then random operations against an arithmetic model.
module tb_nibble_add_sequencer;
  import alu_pkg::*;

  localparam int TIMEOUT = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         op_sub;
  logic [7:0]   x;
  logic [7:0]   y;
  logic         busy;
  logic         done;
  logic         err;
  logic [7:0]   result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         add_en;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         add_ready;
  state_t       dbg_state;

  int           n_checks;
  int           n_fail;
  int           slice_lat;
  int           en_cnt;
  logic [10:0]  exp_q[$];
  logic [10:0]  last_res;

  // Monitor state, owned by tick()
  logic         en_prev;
  logic [8:0]   req_prev;
  int           txn_rises;
  int           rises_total;
  int           low_len;
  logic         hi_cin_seen;

  nibble_add_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_sub    (op_sub),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .add_ready (add_ready),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder slice model: ready slice_lat cycles after en rises, dropped with en.
  always @(posedge clk or posedge rst) begin
    if (rst)          en_cnt <= 0;
    else if (!add_en) en_cnt <= 0;
    else              en_cnt <= en_cnt + 1;
  end
  assign add_ready           = add_en && (en_cnt >= slice_lat);
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {carry, overflow, zero, result} from plain integer arithmetic.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int ures;
    int sres;
    if (sub) begin
      ures = int'(a) - int'(b) + 256;
      sres = int'($signed(a)) - int'($signed(b));
    end else begin
      ures = int'(a) + int'(b);
      sres = int'($signed(a)) + int'($signed(b));
    end
    return {ures >= 256, (sres > 127) || (sres < -128), (ures % 256) == 0, 8'(ures % 256)};
  endfunction

  // Advance to the next falling edge and check the request-side protocol.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      en_prev   = 1'b0;
      txn_rises = 0;
      low_len   = 0;
      return;
    end
    check("done_err_excl", 32'(done & err), 0);
    if (!add_en)
      check("req_idle_zero", 32'({add_a, add_b, add_cin}), 0);
    else if (en_prev)
      check("req_stable", 32'({add_a, add_b, add_cin}), 32'(req_prev));
    if (add_en && !en_prev) begin
      if (txn_rises == 1) begin
        check("en_gap", low_len, 1);
        hi_cin_seen = add_cin;
      end
      txn_rises++;
      rises_total++;
    end else if (!busy) begin
      txn_rises = 0;
    end
    low_len  = add_en ? 0 : low_len + 1;
    en_prev  = add_en;
    req_prev = {add_a, add_b, add_cin};
  endtask

  // Driver: one operation; optional second start or reset at a given cycle.
  task automatic run_op(input logic [7:0] xa, input logic [7:0] ya, input logic sub,
                        input int n_lat, input int restart_at, input int rst_at);
    logic [10:0] exp_v;
    int          lat;
    int          extra;
    int          rises0;
    logic        got_done;
    logic        got_err;
    logic        to_exp;
    slice_lat = n_lat;
    to_exp    = (n_lat >= TIMEOUT);
    if (!to_exp) exp_q.push_back(model(xa, ya, sub));
    rises0   = rises_total;
    x        = xa;
    y        = ya;
    op_sub   = sub;
    start    = 1'b1;
    lat      = 0;
    got_done = 1'b0;
    got_err  = 1'b0;
    while (!got_done && !got_err && lat < 100) begin
      tick();
      lat++;
      got_done = done;
      got_err  = err;
      if (lat == 1) check("busy_after_start", 32'(busy), 1);
      start  = (lat == restart_at);
      x      = 8'($urandom_range(0, 255));
      y      = 8'($urandom_range(0, 255));
      op_sub = 1'($urandom_range(0, 1));
      if (lat == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_async_clear", 32'({busy, add_en, result}), 0);
        exp_q.delete();
        last_res = '0;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        return;
      end
    end
    start = 1'b0;
    if (to_exp) begin
      check("err_pulse", 32'(got_err), 1);
      check("err_latency", lat, TIMEOUT + 1);
      check("err_keeps_result", 32'({carry, overflow, zero, result}), 32'(last_res));
      check("err_idle", 32'({busy, add_en, done}), 0);
    end else begin
      check("done_pulse", 32'(got_done), 1);
      check("done_latency", lat, 2 * (n_lat + 1) + 3);
      check("done_idle", 32'({busy, err}), 0);
      check("en_pulses", rises_total - rises0, 2);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        check("result_flags", 32'({carry, overflow, zero, result}), 32'(exp_v));
        last_res = exp_v;
      end
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || err) extra++;
    end
    check("no_extra_pulse", extra, 0);
    check("idle_after", 32'(busy), 0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    start       = 1'b0;
    op_sub      = 1'b0;
    x           = '0;
    y           = '0;
    slice_lat   = 2;
    last_res    = '0;
    en_prev     = 1'b0;
    req_prev    = '0;
    txn_rises   = 0;
    rises_total = 0;
    low_len     = 0;
    hi_cin_seen = 1'b0;

    repeat (3) tick();
    check("reset_outputs",
          32'({busy, done, err, result, carry, overflow, zero, add_en, add_a, add_b, add_cin}), 0);
    rst = 1'b0;
    tick();

    run_op(8'h3A, 8'h27, OP_ADD, 2, -1, -1);
    check("add_3a_27", 32'({carry, overflow, zero, result}), 32'(11'h061));

    run_op(8'hFF, 8'h01, OP_ADD, 2, -1, -1);
    check("add_ff_01", 32'({carry, overflow, zero, result}), 32'(11'h500));
    check("hi_cin_chained", 32'(hi_cin_seen), 1);

    run_op(8'h80, 8'h01, OP_SUB, 2, -1, -1);
    check("sub_80_01", 32'({carry, overflow, zero, result}), 32'(11'h67F));

    run_op(8'h05, 8'h07, OP_SUB, 2, -1, -1);
    check("sub_05_07", 32'({carry, overflow, zero, result}), 32'(11'h0FE));

    run_op(8'h12, 8'h34, OP_ADD, TIMEOUT, -1, -1);
    check("timeout_keeps", 32'({carry, overflow, zero, result}), 32'(11'h0FE));

    run_op(8'h5A, 8'hA5, OP_ADD, 3, -1, -1);
    check("add_after_timeout", 32'({carry, overflow, zero, result}), 32'(11'h0FF));

    run_op(8'h7F, 8'h01, OP_ADD, TIMEOUT - 1, -1, -1);
    check("ready_beats_timeout", 32'({carry, overflow, zero, result}), 32'(11'h280));

    run_op(8'h11, 8'h22, OP_ADD, 2, 6, -1);
    check("start_while_busy", 32'({carry, overflow, zero, result}), 32'(11'h033));

    run_op(8'h44, 8'h44, OP_ADD, 2, -1, 6);
    run_op(8'hC0, 8'h40, OP_SUB, 1, -1, -1);
    check("sub_after_reset", 32'({carry, overflow, zero, result}), 32'(11'h480));

    for (int k = 0; k < 30; k++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), $urandom_range(0, 4), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
